btb_access_ctrl: RTL and testbench
==================================

// Module: btb_access_ctrl
// PURPOSE
//  Sequences all accesses to the single-port 2-way BTB set RAM (SETS x 128b).
//  Arbitrates fetch lookups against execute-stage branch-resolution updates.
//  Performs update read-modify-write: way select, 2-bit predictor update, target write.
//  Flushes every set at reset release and on request. Lookup data feeds the combinational hit/target read logic.
// PARAMETERS
//  SETS        8   number of sets; IDX_W = $clog2(SETS) = 3
//  TAG_W       27  tag width = 32 - IDX_W - 2 (pc[31:5])
//  STARVE_MAX  4   consecutive stalled cycles after which a pending update beats lookups
// PORTS
//  clk             in   1    clock
//  rst             in   1    asynchronous, active-high reset
//  lkp_valid       in   1    fetch lookup request
//  lkp_pc          in   32   fetch PC; idx = pc[4:2], tag = pc[31:5]
//  lkp_ready       out  1    lookup accepted when lkp_valid & lkp_ready
//  resp_valid      out  1    one-cycle pulse: lookup response valid
//  resp_set_data   out  128  set read for the accepted lookup (mem_rdata passthrough)
//  resp_tag        out  27   tag of the accepted lookup, registered
//  upd_valid       in   1    resolved branch update request
//  upd_pc          in   32   branch PC
//  upd_target      in   32   resolved target
//  upd_taken       in   1    resolved direction
//  upd_ready       out  1    update accepted when upd_valid & upd_ready
//  flush_req       in   1    pulse: invalidate the whole BTB
//  busy            out  1    high while FLUSH or update RMW is in progress
//  mem_en          out  1    RAM enable; read data returns on mem_rdata next cycle
//  mem_we          out  1    RAM write enable (write when mem_en & mem_we)
//  mem_addr        out  3    set index
//  mem_wdata       out  128  set write data
//  mem_rdata       in   128  set read data (1-cycle latency)
// BEHAVIOUR
//  Set layout: way1 = [127:64], way0 = [63:0]. Per way, relative to its base:
//  valid[63], tag[62:36], target[35:4], fsm[3:2]; bits [1:0] written 0.
//  FSM states: FLUSH, IDLE, U_RD, U_WR. Reset -> FLUSH with flush_idx = 0.
//  Reset values: all outputs 0, state FLUSH, repl[SETS-1:0] = 0, starve_cnt = 0.
//  FLUSH: each cycle writes 128'h0 to flush_idx, then increments it. After index SETS-1 -> IDLE (SETS cycles).
//    lkp_ready = upd_ready = 0 and busy = 1 throughout FLUSH. repl bits are cleared.
//  IDLE arbitration (one RAM access per cycle):
//    flush_req beats everything -> FLUSH.
//    else if upd_valid & (!lkp_valid | starve_cnt == STARVE_MAX): accept update -> U_RD.
//    else if lkp_valid: accept lookup and issue a read.
//  Lookups pipeline back-to-back: resp_valid is asserted in the cycle after acceptance.
//  starve_cnt counts cycles with upd_valid & !upd_ready, saturating at STARVE_MAX. It clears on update acceptance.
//  Update RMW path:
//    U_RD: read the set (mem_en = 1, mem_we = 0); latch the update fields; go to U_WR. lkp_ready = 0.
//    U_WR: merge with mem_rdata and write back; go to IDLE. lkp_ready = 0 and busy = 1 during U_RD/U_WR.
//  Way select in U_WR: tag-hit way (way1 wins if both hit). Else the first invalid way (way1 first). Else the repl[idx] way.
//  On hit:
//    taken   -> fsm saturating +1 (max 2'b11); target := upd_target.
//    !taken  -> fsm saturating -1 (min 2'b00); target unchanged.
//  On miss:
//    taken   -> allocate: valid = 1, tag, target, fsm = 2'b10.
//    !taken  -> no write (mem_en = 0 in U_WR).
//  After any write, repl[idx] points to the way NOT written. Lookups never touch repl.
//  flush_req during U_RD/U_WR is held pending. The RMW completes, then FLUSH starts.
//  An update is accepted in the same cycle resp_valid is high for a prior lookup: legal, no conflict.
//  A lookup of the set being updated, issued after U_WR, sees the new data.
//  Reset mid-RMW: no write is issued; the block restarts in FLUSH.
// STRUCTURE
//  Package btb_pkg holds:
//    WAY_W = 64, field bit offsets, btb_way_t packed struct {valid, tag, target, fsm, pad}.
//    Predictor encodings SNT/WNT/WT/ST = 2'b00..11 and the ctrl_state_e enum.
//  Sub-module btb_way_merge (combinational). Inputs: set, tag, target, taken, repl bit.
//    Outputs: new set, write enable, new repl bit.
// TESTING
//  1. Reset release: mem_we = 1 for 8 cycles with addr 0..7, wdata = 0. lkp_ready rises in cycle 9.
//  2. Update pc 0x0000_1004, tgt 0x2000, taken, set empty -> write way1 of idx 1:
//     valid = 1, tag = 0x80, fsm = 2'b10. repl[1] = 0.
//  3. Same pc: taken twice, then not-taken 4 times -> fsm 11, 11, 10, 01, 00, 00.
//  4. Two tags to set 1, then a third tag -> the third overwrites the way named by repl[1].
//     Not-taken miss issues no write.
//  5. lkp_valid held high with upd_valid high -> update is accepted after exactly STARVE_MAX = 4 stalled cycles.
//  6. flush_req during U_RD -> the U_WR write completes, then 8 flush writes. A later lookup returns all-zero set data.

Source files
------------

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - BTB set layout, predictor encodings and controller state type
package btb_pkg;

    localparam int WAY_W     = 64;
    localparam int BTB_TAG_W = 27;
    localparam int VALID_BIT = 63;
    localparam int TAG_LSB   = 36;
    localparam int TGT_LSB   = 4;
    localparam int FSM_LSB   = 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           fsm;
        logic [1:0]           pad;
    } btb_way_t;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        U_RD  = 2'd2,
        U_WR  = 2'd3
    } ctrl_state_e;

    function automatic logic [1:0] fsm_step(input logic [1:0] cur, input logic taken);
        if (taken)
            return (cur == ST) ? ST : cur + 2'b01;
        else
            return (cur == SNT) ? SNT : cur - 2'b01;
    endfunction

endpackage

// File: rtl/btb_way_merge.sv
// rtl/btb_way_merge.sv - way selection and predictor/target merge for an update write-back
module btb_way_merge
    import btb_pkg::*;
(
    input  logic [2*WAY_W-1:0]  set_data,
    input  logic [BTB_TAG_W-1:0] tag,
    input  logic [31:0]         target,
    input  logic                taken,
    input  logic                repl_bit,
    output logic [2*WAY_W-1:0]  new_set,
    output logic                we,
    output logic                new_repl
);

    btb_way_t w0, w1, old_w, new_w;
    logic     hit0, hit1, hit, sel;

    always_comb begin
        w0   = btb_way_t'(set_data[WAY_W-1:0]);
        w1   = btb_way_t'(set_data[2*WAY_W-1:WAY_W]);
        hit1 = w1.valid && (w1.tag == tag);
        hit0 = w0.valid && (w0.tag == tag);
        hit  = hit0 || hit1;

        // hit way first, then an empty way (way1 preferred), then the victim pointer
        if (hit1)           sel = 1'b1;
        else if (hit0)      sel = 1'b0;
        else if (!w1.valid) sel = 1'b1;
        else if (!w0.valid) sel = 1'b0;
        else                sel = repl_bit;

        old_w = sel ? w1 : w0;
        new_w = old_w;
        if (hit) begin
            new_w.fsm = fsm_step(old_w.fsm, taken);
            if (taken)
                new_w.target = target;
        end else begin
            new_w.valid  = 1'b1;
            new_w.tag    = tag;
            new_w.target = target;
            new_w.fsm    = WT;
        end
        new_w.pad = 2'b00;

        new_set  = sel ? {new_w, w0} : {w1, new_w};
        we       = hit || taken;
        new_repl = ~sel;
    end

endmodule

// File: rtl/btb_access_ctrl.sv
// rtl/btb_access_ctrl.sv - single-port BTB RAM sequencer: flush, lookup/update arbitration, update RMW
module btb_access_ctrl
    import btb_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int IDX_W      = $clog2(SETS),
    parameter int TAG_W      = 32 - IDX_W - 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lkp_valid,
    input  logic [31:0]        lkp_pc,
    output logic               lkp_ready,
    output logic               resp_valid,
    output logic [127:0]       resp_set_data,
    output logic [TAG_W-1:0]   resp_tag,
    input  logic               upd_valid,
    input  logic [31:0]        upd_pc,
    input  logic [31:0]        upd_target,
    input  logic               upd_taken,
    output logic               upd_ready,
    input  logic               flush_req,
    output logic               busy,
    output logic               mem_en,
    output logic               mem_we,
    output logic [IDX_W-1:0]   mem_addr,
    output logic [127:0]       mem_wdata,
    input  logic [127:0]       mem_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    ctrl_state_e        state, state_nxt;
    logic [IDX_W-1:0]   flush_idx;
    logic [SETS-1:0]    repl;
    logic [SC_W-1:0]    starve_cnt;
    logic               flush_pend;
    logic [IDX_W-1:0]   u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic [31:0]        u_target;
    logic               u_taken;

    logic [IDX_W-1:0]   lkp_idx;
    logic [TAG_W-1:0]   lkp_tag;
    logic [127:0]       m_set;
    logic               m_we;
    logic               m_repl;
    logic               starved;

    assign lkp_idx       = lkp_pc[IDX_W+1:2];
    assign lkp_tag       = lkp_pc[31:IDX_W+2];
    assign starved       = (starve_cnt == SC_W'(STARVE_MAX));
    assign resp_set_data = mem_rdata;

    btb_way_merge u_merge (
        .set_data (mem_rdata),
        .tag      (u_tag),
        .target   (u_target),
        .taken    (u_taken),
        .repl_bit (repl[u_idx]),
        .new_set  (m_set),
        .we       (m_we),
        .new_repl (m_repl)
    );

    always_comb begin
        state_nxt = state;
        lkp_ready = 1'b0;
        upd_ready = 1'b0;
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            FLUSH: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = flush_idx;
                if (flush_idx == IDX_W'(SETS - 1))
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else begin
                    upd_ready = !lkp_valid || starved;
                    lkp_ready = !(upd_valid && upd_ready);
                    if (upd_valid && upd_ready) begin
                        state_nxt = U_RD;
                    end else if (lkp_valid) begin
                        mem_en   = 1'b1;
                        mem_addr = lkp_idx;
                    end
                end
            end
            U_RD: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = u_idx;
                state_nxt = U_WR;
            end
            U_WR: begin
                busy      = 1'b1;
                mem_en    = m_we;
                mem_we    = m_we;
                mem_addr  = u_idx;
                mem_wdata = m_set;
                state_nxt = (flush_pend || flush_req) ? FLUSH : IDLE;
            end
            default: state_nxt = FLUSH;
        endcase
        // keep the RAM quiet while reset is held, even mid-RMW
        if (rst) begin
            lkp_ready = 1'b0;
            upd_ready = 1'b0;
            busy      = 1'b0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FLUSH;
            flush_idx  <= '0;
            repl       <= '0;
            starve_cnt <= '0;
            flush_pend <= 1'b0;
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            u_idx      <= '0;
            u_tag      <= '0;
            u_target   <= '0;
            u_taken    <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= lkp_valid && lkp_ready;
            if (lkp_valid && lkp_ready)
                resp_tag <= lkp_tag;

            if (state == FLUSH) begin
                flush_idx  <= flush_idx + 1'b1;
                repl       <= '0;
                flush_pend <= 1'b0;
            end else begin
                flush_idx <= '0;
            end

            if ((state == U_RD || state == U_WR) && flush_req)
                flush_pend <= 1'b1;

            if (upd_valid && upd_ready) begin
                u_idx      <= upd_pc[IDX_W+1:2];
                u_tag      <= upd_pc[31:IDX_W+2];
                u_target   <= upd_target;
                u_taken    <= upd_taken;
                starve_cnt <= '0;
            end else if (upd_valid && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == U_WR && m_we)
                repl[u_idx] <= m_repl;
        end
    end

endmodule

// File: tb/tb_btb_access_ctrl.sv
// tb/tb_btb_access_ctrl.sv - directed self-checking bench for btb_access_ctrl
module tb_btb_access_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         lkp_valid;
    logic [31:0]  lkp_pc;
    logic         lkp_ready;
    logic         resp_valid;
    logic [127:0] resp_set_data;
    logic [26:0]  resp_tag;
    logic         upd_valid;
    logic [31:0]  upd_pc;
    logic [31:0]  upd_target;
    logic         upd_taken;
    logic         upd_ready;
    logic         flush_req;
    logic         busy;
    logic         mem_en;
    logic         mem_we;
    logic [2:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    logic [127:0] ram [8];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (mem_en)      mem_rdata <= ram[mem_addr];
    end

    btb_access_ctrl dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_ready(lkp_ready),
        .resp_valid(resp_valid), .resp_set_data(resp_set_data), .resp_tag(resp_tag),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_ready(upd_ready),
        .flush_req(flush_req), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] mkway(input logic v, input logic [26:0] tg,
                                          input logic [31:0] tgt, input logic [1:0] f);
        return {v, tg, tgt, f, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        #1;
    endtask

    // from the accept cycle: walk U_RD then sample the U_WR write port
    task automatic run_rmw(input logic [2:0] idx, input logic flush_in_rd,
                           output logic wr, output logic [127:0] wd);
        @(negedge clk);
        upd_valid = 1'b0;
        lkp_valid = 1'b0;
        flush_req = flush_in_rd;
        #1;
        chk("urd_read", {busy, lkp_ready, mem_en, mem_we, 5'(mem_addr)}, {4'b1010, 5'(idx)});
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        wr = mem_en & mem_we;
        wd = mem_wdata;
    endtask

    logic         wr;
    logic [127:0] wd;
    logic [1:0]   exp_fsm [6] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    logic         tk_seq  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0]  tgt_seq [6] = '{32'h2100, 32'h2000, 32'hdead0, 32'hdead0, 32'hdead0, 32'hdead0};
    logic [31:0]  cur_tgt;
    int           stalls;
    logic         got;

    initial begin
        rst = 1'b1; lkp_valid = 1'b0; lkp_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_target = '0; upd_taken = 1'b0; flush_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {lkp_ready, upd_ready, resp_valid, busy, mem_en, mem_we}, 6'b0);

        // reset release: 8 flush writes, then lookups open
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("flush_%0d", i), {busy, lkp_ready, mem_we, 5'(mem_addr)}, {3'b101, 5'(i)});
            chk($sformatf("flush_wdata_%0d", i), mem_wdata, 128'h0);
            step();
        end
        chk("ready_after_flush", {lkp_ready, busy}, 2'b10);

        // first allocation into empty set 1
        issue_upd(32'h0000_1004, 32'h2000, 1'b1);
        chk("upd_ready_idle", upd_ready, 1'b1);
        run_rmw(3'd1, 1'b0, wr, wd);
        chk("alloc_we", wr, 1'b1);
        chk("alloc_wdata", wd, 128'h8000_0800_0002_0008_0000_0000_0000_0000);
        step();
        chk("alloc_repl1", dut.repl[1], 1'b0);

        // predictor saturation both ways; not-taken keeps the target
        cur_tgt = 32'h2000;
        for (int i = 0; i < 6; i++) begin
            issue_upd(32'h0000_1004, tgt_seq[i], tk_seq[i]);
            run_rmw(3'd1, 1'b0, wr, wd);
            if (tk_seq[i]) cur_tgt = tgt_seq[i];
            chk($sformatf("ctr_%0d", i), wd, {mkway(1'b1, 27'h80, cur_tgt, exp_fsm[i]), 64'h0});
            chk($sformatf("ctr_we_%0d", i), wr, 1'b1);
            step();
        end

        // back-to-back lookups
        lkp_valid = 1'b1; lkp_pc = 32'h0000_1004;
        #1;
        chk("lkp_ready", lkp_ready, 1'b1);
        step();
        lkp_pc = 32'h0000_0008;
        #1;
        chk("lkp0_resp", {resp_valid, resp_tag}, {1'b1, 27'h80});
        chk("lkp0_data", resp_set_data, {mkway(1'b1, 27'h80, 32'h2000, 2'b00), 64'h0});
        step();
        lkp_valid = 1'b0;
        #1;
        chk("lkp1_resp", {resp_valid, resp_tag}, {1'b1, 27'h0});
        chk("lkp1_data", resp_set_data, 128'h0);
        step();
        chk("lkp_resp_pulse", resp_valid, 1'b0);

        // fill way0, then replace via repl[1]
        issue_upd(32'h0000_2004, 32'h3000, 1'b1);
        run_rmw(3'd1, 1'b0, wr, wd);
        chk("fill_way0", wd, {mkway(1'b1, 27'h80, 32'h2000, 2'b00), mkway(1'b1, 27'h100, 32'h3000, 2'b10)});
        step();
        chk("fill_repl1", dut.repl[1], 1'b1);
        issue_upd(32'h0000_3004, 32'h4000, 1'b1);
        run_rmw(3'd1, 1'b0, wr, wd);
        chk("replace_way1", wd, {mkway(1'b1, 27'h180, 32'h4000, 2'b10), mkway(1'b1, 27'h100, 32'h3000, 2'b10)});
        step();
        chk("replace_repl1", dut.repl[1], 1'b0);
        issue_upd(32'h0000_4004, 32'h5000, 1'b0);
        run_rmw(3'd1, 1'b0, wr, wd);
        chk("nt_miss_no_en", mem_en, 1'b0);
        step();
        chk("nt_miss_ram", ram[1], {mkway(1'b1, 27'h180, 32'h4000, 2'b10), mkway(1'b1, 27'h100, 32'h3000, 2'b10)});

        // starvation: lookups held, update waits exactly STARVE_MAX cycles
        lkp_valid = 1'b1; lkp_pc = 32'h0000_0010;
        upd_valid = 1'b1; upd_pc = 32'h0000_3004; upd_target = 32'h4000; upd_taken = 1'b1;
        stalls = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (upd_ready) begin got = 1'b1; break; end
            stalls++;
            @(negedge clk);
        end
        chk("starve_accept", got, 1'b1);
        chk("starve_cycles", stalls, 4);
        chk("starve_lkp_blocked", lkp_ready, 1'b0);
        chk("starve_resp_overlap", resp_valid, 1'b1);
        run_rmw(3'd1, 1'b0, wr, wd);
        chk("starve_wdata", wd, {mkway(1'b1, 27'h180, 32'h4000, 2'b11), mkway(1'b1, 27'h100, 32'h3000, 2'b10)});
        step();

        // flush request during U_RD: write lands, then full flush
        issue_upd(32'h0000_0008, 32'h5000, 1'b1);
        run_rmw(3'd2, 1'b1, wr, wd);
        chk("pend_we", wr, 1'b1);
        chk("pend_wdata", wd, {mkway(1'b1, 27'h0, 32'h5000, 2'b10), 64'h0});
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reflush_%0d", i), {busy, mem_we, 5'(mem_addr), mem_wdata}, {2'b11, 5'(i), 128'h0});
            step();
        end
        chk("reflush_repl", dut.repl, 8'h0);
        lkp_valid = 1'b1; lkp_pc = 32'h0000_0008;
        #1;
        chk("post_flush_lkp_ready", lkp_ready, 1'b1);
        step();
        lkp_valid = 1'b0;
        #1;
        chk("post_flush_resp", {resp_valid, resp_set_data}, {1'b1, 128'h0});

        // reset mid-RMW: no write, restart in FLUSH
        step();
        issue_upd(32'h0000_1004, 32'h1234, 1'b1);
        step();
        upd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rmw_quiet", {mem_en, mem_we, busy}, 3'b000);
        step();
        rst = 1'b0;
        #1;
        chk("rst_rmw_restart", {busy, mem_we, 5'(mem_addr)}, {2'b11, 5'd0});
        chk("rst_rmw_ram", ram[1], 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
